sha3_pad_stream: RTL

Upstream feeder for AXI_SHA. Accepts a raw message as a stream of 16-bit words and applies SHA3 pad10*1 padding with domain byte 0x06. Emits rate-sized blocks as a 16-bit word stream with block and message boundary flags. The output stream is what AXI_SHA absorbs as in_data and SHA_valid, with how_to_last driven from m_msg_last.

---
 rtl/sha3_pad_stream_if.sv | 28 ++
 rtl/sha3_pad_stream.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sha3_pad_stream_if.sv
// Stream interface for sha3_pad_stream.
//   s_* : raw message words in (byte0 = s_data[7:0], byte1 = s_data[15:8])
//   m_* : padded rate-block words out, with block / message boundary flags
// Modports: master = stream source and sink around the block, slave = the padder.
interface sha3_pad_stream_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] s_data;
  logic [1:0]       s_keep;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_block_last;
  logic             m_msg_last;

  modport master (
    output s_data, s_keep, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_block_last, m_msg_last
  );

  modport slave (
    input  s_data, s_keep, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_block_last, m_msg_last
  );
endinterface

// File: rtl/sha3_pad_stream.sv
// SHA3 pad10*1 padder (domain byte 0x06) feeding AXI_SHA.
// Accepts a message as 16-bit words and emits rate-sized blocks as 16-bit words,
// flagging the last word of each block and of the whole padded message.
// Ports:
//   ACLK    : clock, rising edge
//   ARESETn : asynchronous active-low reset
//   ID      : SHA3 variant (0=224, 1=256, 2=384, 3=512), latched on first word of a message
//   bus_io  : s_* input stream and m_* output stream (single output register stage)
module sha3_pad_stream #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [1:0]        ID,
  sha3_pad_stream_if.slave  bus_io
);

  typedef enum logic [0:0] {SData, SPad} state_e;

  state_e           state_q;
  logic [6:0]       word_cnt_q;
  logic             pad_started_q;
  logic             msg_active_q;
  logic [1:0]       id_q;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid_q;
  logic             m_block_last_q;
  logic             m_msg_last_q;

  logic [1:0] id_eff;
  logic [6:0] rw_last;
  logic       at_end;
  logic [6:0] cnt_next;
  logic       out_free;
  logic       s_ready;
  logic       accept;
  logic [7:0] pad_hi;
  logic [7:0] pad_lo;
  logic       last_done;

  always_comb begin
    // The first word of a message sees the live ID; afterwards the latched one.
    id_eff = msg_active_q ? id_q : ID;
    case (id_eff)
      2'd0:    rw_last = 7'd71;
      2'd1:    rw_last = 7'd67;
      2'd2:    rw_last = 7'd51;
      default: rw_last = 7'd35;
    endcase
    at_end    = (word_cnt_q == rw_last);
    cnt_next  = at_end ? 7'd0 : word_cnt_q + 7'd1;
    out_free  = !m_valid_q || bus_io.m_ready;
    s_ready   = ARESETn && (state_q == SData) && out_free;
    accept    = bus_io.s_valid && s_ready;
    pad_hi    = at_end ? 8'h80 : 8'h00;
    pad_lo    = pad_started_q ? 8'h00 : 8'h06;
    // keep=01/00 put the 0x06 byte into this word; message ends here if it is the block end.
    last_done = at_end && !bus_io.s_keep[1];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q        <= SData;
      word_cnt_q     <= '0;
      pad_started_q  <= 1'b0;
      msg_active_q   <= 1'b0;
      id_q           <= '0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      m_block_last_q <= 1'b0;
      m_msg_last_q   <= 1'b0;
    end else begin
      if (m_valid_q && bus_io.m_ready) begin
        m_valid_q <= 1'b0;
      end
      case (state_q)
        SData: begin
          if (accept) begin
            id_q           <= id_eff;
            msg_active_q   <= 1'b1;
            m_valid_q      <= 1'b1;
            word_cnt_q     <= cnt_next;
            m_block_last_q <= at_end;
            m_msg_last_q   <= 1'b0;
            if (!bus_io.s_last) begin
              m_data_q <= bus_io.s_data;
            end else begin
              case (bus_io.s_keep)
                2'b01: begin
                  m_data_q      <= {(at_end ? 8'h86 : 8'h06), bus_io.s_data[7:0]};
                  m_msg_last_q  <= at_end;
                  pad_started_q <= 1'b1;
                end
                2'b00: begin
                  m_data_q      <= {pad_hi, 8'h06};
                  m_msg_last_q  <= at_end;
                  pad_started_q <= 1'b1;
                end
                default: begin
                  m_data_q      <= bus_io.s_data;
                  pad_started_q <= 1'b0;
                end
              endcase
              if (last_done) begin
                msg_active_q <= 1'b0;
              end else begin
                state_q <= SPad;
              end
            end
          end
        end
        SPad: begin
          if (out_free) begin
            m_valid_q      <= 1'b1;
            m_data_q       <= {pad_hi, pad_lo};
            m_block_last_q <= at_end;
            m_msg_last_q   <= at_end;
            pad_started_q  <= 1'b1;
            word_cnt_q     <= cnt_next;
            if (at_end) begin
              state_q      <= SData;
              msg_active_q <= 1'b0;
            end
          end
        end
        default: state_q <= SData;
      endcase
    end
  end

  assign bus_io.s_ready      = s_ready;
  assign bus_io.m_data       = m_data_q;
  assign bus_io.m_valid      = m_valid_q;
  assign bus_io.m_block_last = m_block_last_q;
  assign bus_io.m_msg_last   = m_msg_last_q;

endmodule
